hls_deadlock_reporter: RTL and testbench
========================================

HLS_DEADLOCK_REPORTER -- requirements
Module: hls_deadlock_reporter

Interface
REQ-001 SHALL have parameter STALL_THRESHOLD, default 16: consecutive `block` cycles needed to qualify a deadlock; legal range 1..65535.
REQ-002 SHALL have parameter TS_W, default 32: timestamp width.
REQ-003 SHALL have parameter CNT_W, default 8: event-counter width.
REQ-004 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port block, input, 1: registered deadlock indication from the top-level deadlock monitor.
REQ-007 SHALL have port axis_block_sigs, input, 2: per-AXIS-channel block flags, snapshotted with each report.
REQ-008 SHALL have port rpt_valid, output, 1: report record valid.
REQ-009 SHALL have port rpt_ready, input, 1: report consumer ready.
REQ-010 SHALL have port rpt_timestamp, output, TS_W: timestamp of the first `block` cycle of the qualified episode.
REQ-011 SHALL have port rpt_axis, output, 2: axis_block_sigs sampled on the qualifying cycle.
REQ-012 SHALL have port rpt_count, output, CNT_W: number of qualified episodes including this one; saturating.
REQ-013 SHALL have port irq, output, 1: sticky deadlock flag.
REQ-014 SHALL have port irq_clear, input, 1: single-cycle clear of irq.

Function
REQ-015 SHALL keep a free-running TS_W timestamp counter that increments every cycle and wraps from all-ones to 0.
REQ-016 SHALL implement the FSM states IDLE, QUALIFY, REPORT and WAIT_RELEASE.
REQ-017 IDLE: when block=1, SHALL capture the current timestamp into a start register, load the run counter with 1, and go to QUALIFY; if STALL_THRESHOLD=1, SHALL instead go directly to REPORT, performing the REQ-019 captures.
REQ-018 QUALIFY: when block=0, SHALL return to IDLE with nothing reported; otherwise it SHALL increment the run counter.
REQ-019 QUALIFY: on the cycle the run counter reaches STALL_THRESHOLD, SHALL latch rpt_axis from axis_block_sigs, increment the saturating event count, set irq, and go to REPORT.
REQ-020 REPORT: rpt_valid SHALL be 1, and rpt_timestamp, rpt_axis and rpt_count SHALL be held stable until the handshake completes (rpt_valid and rpt_ready both 1 at a clock edge).
REQ-021 REPORT: when the handshake completes, SHALL go to WAIT_RELEASE; block changing during REPORT SHALL NOT abort the report.
REQ-022 WAIT_RELEASE: SHALL stay in this state while block=1 and go to IDLE on the first cycle block=0, so that one continuous episode gives exactly one report.
REQ-023 Latency: rpt_valid SHALL rise exactly STALL_THRESHOLD cycles after the first sampled block=1.
REQ-024 The event count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 irq SHALL be set by qualification and cleared by irq_clear; simultaneous set and clear SHALL leave irq=1.
REQ-026 irq_clear SHALL NOT affect the FSM, the event count or a pending report.
REQ-027 The run counter SHALL be 16 bits wide.
REQ-028 rpt_valid SHALL NOT depend combinationally on rpt_ready.

Reset
REQ-029 Reset asserted SHALL force: FSM to IDLE, rpt_valid=0, rpt_timestamp=0, rpt_axis=0, rpt_count=0, irq=0, timestamp counter=0, run counter=0.
REQ-030 Reset asserted mid-QUALIFY or mid-REPORT SHALL discard the pending record; after release, reporting SHALL restart from IDLE.
REQ-031 Reset release SHALL be synchronised by two flops before it reaches the FSM; the assertion path SHALL stay asynchronous.

Structure
REQ-032 The FSM state encoding and the default widths SHALL live in the shared package hls_deadlock_pkg.
REQ-033 The reset synchroniser SHALL be the single sub-module, hls_deadlock_rst_sync.

Verification
REQ-034 The bench SHALL cover: STALL_THRESHOLD=16, block high 20 cycles starting at timestamp 100, rpt_ready=1 -> one report, rpt_valid on cycle 16 of the episode, rpt_timestamp=100, rpt_count=1, irq=1.
REQ-035 The bench SHALL cover: block high 15 cycles then low -> no rpt_valid, irq=0, count unchanged.
REQ-036 The bench SHALL cover: qualified report with rpt_ready=0 for 10 cycles while block toggles and axis_block_sigs changes -> record stable, one handshake only when rpt_ready=1.
REQ-037 The bench SHALL cover: CNT_W=2 with 5 qualified episodes -> rpt_count values 1, 2, 3, 3, 3.
REQ-038 The bench SHALL cover: irq_clear on the same cycle as qualification -> irq=1; irq_clear one cycle later -> irq=0.
REQ-039 The bench SHALL cover: reset asserted during REPORT -> outputs reach reset values asynchronously; a fresh 16-cycle episode after release -> rpt_count=1.

Source files
------------

// File: rtl/hls_deadlock_pkg.sv
// Shared definitions for the HLS deadlock reporter: FSM encoding and default widths.
package hls_deadlock_pkg;

    localparam int unsigned DEF_STALL_THRESHOLD = 16;
    localparam int unsigned DEF_TS_W            = 32;
    localparam int unsigned DEF_CNT_W           = 8;
    localparam int unsigned RUN_W               = 16;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_QUALIFY      = 2'd1;
    localparam logic [1:0] ST_REPORT       = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

endpackage

// File: rtl/hls_deadlock_rst_sync.sv
// Reset synchroniser: assertion passes straight through, release is delayed by two flops.
module hls_deadlock_rst_sync (
    input  logic clock,
    input  logic reset,
    output logic reset_sync
);

    logic meta_r;
    logic sync_r;

    // Two-stage release synchroniser with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= 1'b1;
            sync_r <= meta_r;
        end
    end

    assign reset_sync = sync_r;

endmodule

// File: rtl/hls_deadlock_reporter.sv
// Qualifies sustained deadlock indications and emits one timestamped report record per episode.
module hls_deadlock_reporter
    import hls_deadlock_pkg::*;
#(
    parameter int unsigned STALL_THRESHOLD = DEF_STALL_THRESHOLD,
    parameter int unsigned TS_W            = DEF_TS_W,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             block,
    input  logic [1:0]       axis_block_sigs,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [TS_W-1:0]  rpt_timestamp,
    output logic [1:0]       rpt_axis,
    output logic [CNT_W-1:0] rpt_count,
    output logic             irq,
    input  logic             irq_clear
);

    localparam logic [RUN_W-1:0] THRESH  = RUN_W'(STALL_THRESHOLD);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic             rst_sync_n_s;
    logic [1:0]       state_r,         state_nx_s;
    logic [RUN_W-1:0] run_cnt_r,       run_nx_s;
    logic [RUN_W-1:0] run_inc_s;
    logic [TS_W-1:0]  ts_r;
    logic [TS_W-1:0]  start_ts_r,      start_nx_s;
    logic [TS_W-1:0]  rpt_timestamp_r, ts_out_nx_s;
    logic             rpt_valid_r,     valid_nx_s;
    logic [1:0]       rpt_axis_r,      axis_nx_s;
    logic [CNT_W-1:0] rpt_count_r,     count_nx_s;
    logic             irq_r,           irq_nx_s;
    logic             qualify_s;

    hls_deadlock_rst_sync u_rst_sync (
        .clock      (clock),
        .reset      (reset),
        .reset_sync (rst_sync_n_s)
    );

    assign run_inc_s  = run_cnt_r + RUN_ONE;
    assign axis_nx_s  = qualify_s ? axis_block_sigs : rpt_axis_r;
    assign count_nx_s = qualify_s ? sat_inc(rpt_count_r) : rpt_count_r;
    // Qualification wins over a coincident clear so no episode goes unflagged
    assign irq_nx_s   = qualify_s ? 1'b1 : (irq_clear ? 1'b0 : irq_r);

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clock or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_ONE;
        end
    end

    // Next-state and record-capture logic
    always_comb begin
        state_nx_s  = state_r;
        run_nx_s    = run_cnt_r;
        start_nx_s  = start_ts_r;
        valid_nx_s  = rpt_valid_r;
        ts_out_nx_s = rpt_timestamp_r;
        qualify_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (block) begin
                    start_nx_s = ts_r;
                    run_nx_s   = RUN_ONE;
                    if (THRESH == RUN_ONE) begin
                        qualify_s   = 1'b1;
                        valid_nx_s  = 1'b1;
                        ts_out_nx_s = ts_r;
                        state_nx_s  = ST_REPORT;
                    end else begin
                        state_nx_s = ST_QUALIFY;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_QUALIFY: begin
                if (!block) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    run_nx_s = run_inc_s;
                    if (run_inc_s == THRESH) begin
                        qualify_s   = 1'b1;
                        valid_nx_s  = 1'b1;
                        ts_out_nx_s = start_ts_r;
                        state_nx_s  = ST_REPORT;
                    end else begin
                        state_nx_s = ST_QUALIFY;
                    end
                end
            end
            ST_REPORT: begin
                // block is deliberately ignored here: a report is never aborted
                if (rpt_ready) begin
                    valid_nx_s = 1'b0;
                    state_nx_s = ST_WAIT_RELEASE;
                end else begin
                    valid_nx_s = 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!block) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                valid_nx_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            state_r         <= ST_IDLE;
            run_cnt_r       <= '0;
            start_ts_r      <= '0;
            rpt_valid_r     <= 1'b0;
            rpt_timestamp_r <= '0;
            rpt_axis_r      <= 2'b00;
            rpt_count_r     <= '0;
            irq_r           <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            run_cnt_r       <= run_nx_s;
            start_ts_r      <= start_nx_s;
            rpt_valid_r     <= valid_nx_s;
            rpt_timestamp_r <= ts_out_nx_s;
            rpt_axis_r      <= axis_nx_s;
            rpt_count_r     <= count_nx_s;
            irq_r           <= irq_nx_s;
        end
    end

    assign rpt_valid     = rpt_valid_r;
    assign rpt_timestamp = rpt_timestamp_r;
    assign rpt_axis      = rpt_axis_r;
    assign rpt_count     = rpt_count_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Self-checking bench: directed scenarios plus random traffic against an episode-level reference model.
module tb_hls_deadlock_reporter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       block = 1'b0;
    logic       block2 = 1'b0;
    logic [1:0] axis_sigs = 2'b00;
    logic       rpt_ready = 1'b1;
    logic       irq_clear = 1'b0;

    logic        rv0, rv1, irq0, irq1;
    logic [31:0] rts0;
    logic [7:0]  rts1;
    logic [1:0]  rax0, rax1;
    logic [7:0]  rc0;
    logic [1:0]  rc1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    hls_deadlock_reporter dut0 (
        .clock(clock), .reset(reset), .block(block), .axis_block_sigs(axis_sigs),
        .rpt_valid(rv0), .rpt_ready(rpt_ready), .rpt_timestamp(rts0), .rpt_axis(rax0),
        .rpt_count(rc0), .irq(irq0), .irq_clear(irq_clear)
    );

    hls_deadlock_reporter #(.STALL_THRESHOLD(1), .TS_W(8), .CNT_W(2)) dut1 (
        .clock(clock), .reset(reset), .block(block2), .axis_block_sigs(axis_sigs),
        .rpt_valid(rv1), .rpt_ready(rpt_ready), .rpt_timestamp(rts1), .rpt_axis(rax1),
        .rpt_count(rc1), .irq(irq1), .irq_clear(irq_clear)
    );

    // Reference model: episodes of consecutive block samples, one pending record at most
    int          thr   [2] = '{16, 1};
    logic [7:0]  cmax  [2] = '{8'd255, 8'd3};
    logic [31:0] tmask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_ts [2], m_start [2], m_rts [2];
    logic [1:0]  m_rax [2];
    logic [7:0]  m_rcnt [2];
    bit          m_pend [2], m_need [2], m_irq [2];
    int          m_run [2], m_rel [2];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_ts[d] = 0; m_start[d] = 0; m_rts[d] = 0; m_rax[d] = 0; m_rcnt[d] = 0;
                m_pend[d] = 0; m_need[d] = 0; m_irq[d] = 0; m_run[d] = 0; m_rel[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit b;
                bit qual;
                b = (d == 0) ? block : block2;
                qual = 0;
                if (m_rel[d] < 2) begin
                    m_rel[d]++;
                end else begin
                    if (m_pend[d]) begin
                        if (rpt_ready) begin
                            m_pend[d] = 0;
                            m_need[d] = 1;
                        end
                    end else if (m_need[d]) begin
                        if (!b) m_need[d] = 0;
                    end else if (b) begin
                        if (m_run[d] == 0) m_start[d] = m_ts[d];
                        m_run[d]++;
                        if (m_run[d] == thr[d]) begin
                            qual = 1;
                            m_pend[d] = 1;
                            m_rts[d] = m_start[d];
                            m_rax[d] = axis_sigs;
                            m_rcnt[d] = (m_rcnt[d] == cmax[d]) ? cmax[d] : m_rcnt[d] + 8'd1;
                            m_run[d] = 0;
                        end
                    end else begin
                        m_run[d] = 0;
                    end
                    if (qual) m_irq[d] = 1;
                    else if (irq_clear) m_irq[d] = 0;
                    m_ts[d] = (m_ts[d] + 32'd1) & tmask[d];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("m0_valid", 32'(rv0),  32'(m_pend[0]));
        chk("m0_irq",   32'(irq0), 32'(m_irq[0]));
        chk("m0_ts",    rts0,      m_rts[0]);
        chk("m0_axis",  32'(rax0), 32'(m_rax[0]));
        chk("m0_count", 32'(rc0),  32'(m_rcnt[0]));
        chk("m1_valid", 32'(rv1),  32'(m_pend[1]));
        chk("m1_irq",   32'(irq1), 32'(m_irq[1]));
        chk("m1_ts",    32'(rts1), m_rts[1]);
        chk("m1_axis",  32'(rax1), 32'(m_rax[1]));
        chk("m1_count", 32'(rc1),  32'(m_rcnt[1]));
    endtask

    task automatic cycle();
        @(negedge clock);
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [1:0]  exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [31:0] held_ts;
        logic [1:0]  held_ax;
        int guard;
        int run0, run1;
        bit lvl0, lvl1;

        cycles(3);
        chk("reset_valid", 32'(rv0), 32'd0);
        chk("reset_count", 32'(rc0), 32'd0);
        reset = 1'b1;

        // Long episode starting at timestamp 100
        guard = 0;
        while (m_ts[0] != 32'd100 && guard < 300) begin
            cycle();
            guard++;
        end
        chk("ts_reach_100_timeout", m_ts[0], 32'd100);
        block = 1'b1;
        rpt_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            chk("lat_valid", 32'(rv0), 32'(i == 16));
        end
        chk("ep1_ts", rts0, 32'd100);
        chk("ep1_count", 32'(rc0), 32'd1);
        chk("ep1_irq", 32'(irq0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("ep1_single", 32'(rv0), 32'd0);
        end
        block = 1'b0;
        cycles(3);

        // Short episode never qualifies
        irq_clear = 1'b1;
        cycle();
        irq_clear = 1'b0;
        chk("irq_cleared", 32'(irq0), 32'd0);
        block = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            chk("short_valid", 32'(rv0), 32'd0);
        end
        block = 1'b0;
        cycles(3);
        chk("short_irq", 32'(irq0), 32'd0);
        chk("short_count", 32'(rc0), 32'd1);
        chk("short_valid_end", 32'(rv0), 32'd0);

        // Back-pressured report stays stable while inputs churn
        rpt_ready = 1'b0;
        axis_sigs = 2'b10;
        block = 1'b1;
        cycles(16);
        chk("bp_valid", 32'(rv0), 32'd1);
        chk("bp_axis", 32'(rax0), 32'd2);
        held_ts = m_rts[0];
        held_ax = 2'b10;
        for (int i = 0; i < 10; i++) begin
            block = 1'($urandom_range(0, 1));
            axis_sigs = 2'($urandom_range(0, 3));
            cycle();
            chk("bp_hold_valid", 32'(rv0), 32'd1);
            chk("bp_hold_ts", rts0, held_ts);
            chk("bp_hold_axis", 32'(rax0), 32'(held_ax));
            chk("bp_hold_count", 32'(rc0), 32'd2);
        end
        block = 1'b0;
        rpt_ready = 1'b1;
        cycle();
        chk("bp_handshake", 32'(rv0), 32'd0);
        cycles(3);
        chk("bp_once", 32'(rv0), 32'd0);
        chk("bp_count", 32'(rc0), 32'd2);

        // Clear coincident with qualification loses to the set
        irq_clear = 1'b1;
        cycle();
        irq_clear = 1'b0;
        block = 1'b1;
        cycles(15);
        irq_clear = 1'b1;
        cycle();
        chk("irq_set_wins", 32'(irq0), 32'd1);
        chk("irq_set_valid", 32'(rv0), 32'd1);
        cycle();
        chk("irq_clear_later", 32'(irq0), 32'd0);
        irq_clear = 1'b0;
        block = 1'b0;
        cycles(3);

        // Saturating 2-bit count on the single-cycle-threshold instance
        for (int k = 0; k < 5; k++) begin
            block2 = 1'b1;
            cycle();
            chk("sat_valid", 32'(rv1), 32'd1);
            chk("sat_count", 32'(rc1), 32'(exp_cnt[k]));
            block2 = 1'b0;
            cycles(2);
            chk("sat_released", 32'(rv1), 32'd0);
        end

        // Reset during a pending report
        rpt_ready = 1'b0;
        block = 1'b1;
        cycles(18);
        chk("pre_rst_valid", 32'(rv0), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(rv0), 32'd0);
        chk("arst_ts", rts0, 32'd0);
        chk("arst_axis", 32'(rax0), 32'd0);
        chk("arst_count", 32'(rc0), 32'd0);
        chk("arst_irq", 32'(irq0), 32'd0);
        cycles(2);
        reset = 1'b1;
        block = 1'b0;
        rpt_ready = 1'b1;
        cycles(3);
        block = 1'b1;
        cycles(16);
        chk("post_rst_valid", 32'(rv0), 32'd1);
        chk("post_rst_count", 32'(rc0), 32'd1);
        block = 1'b0;
        cycles(3);

        // Random traffic against the model
        run0 = 0; run1 = 0; lvl0 = 0; lvl1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run0 == 0) begin
                lvl0 = !lvl0;
                run0 = lvl0 ? $urandom_range(1, 24) : $urandom_range(1, 4);
            end
            if (run1 == 0) begin
                lvl1 = !lvl1;
                run1 = lvl1 ? $urandom_range(1, 6) : $urandom_range(1, 4);
            end
            run0--; run1--;
            block = lvl0;
            block2 = lvl1;
            rpt_ready = ($urandom_range(0, 3) != 0);
            irq_clear = ($urandom_range(0, 15) == 0);
            axis_sigs = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
